// File: rtl/sliding_window_gen_pkg.sv
// Shared constants and helpers for the Sobel/Gaussian front-end blocks.
// The window generator and its bus interface import this package.
package sobel_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;

  // Bit offset of window element (r,c) in a flattened KxK window.
  // Row 0 is the oldest line; column 0 is the oldest pixel.
  function automatic int idx(input int r, input int c, input int k, input int dw);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out bus of the sliding window generator.
// master = pixel source plus window consumer, slave = the generator.
interface sliding_window_gen_if
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = 3,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic                     in_valid;
  logic                     in_sof;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid;
  logic [K*K*DATA_W-1:0]    out_window;
  logic [XW-1:0]            out_x;
  logic [YW-1:0]            out_y;
  logic                     frame_done;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_window, out_x, out_y, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_window, out_x, out_y, frame_done
  );

endinterface

// File: rtl/sliding_window_gen_line_buffer.sv
// One line of pixel storage. Registered read port and a write port
// sharing one clock; maps onto block or distributed RAM.
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read every cycle, write on enable; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Streaming KxK window generator for raster-scan pixels.
// K-1 chained line buffers supply the upper rows of each new column; a
// KxK register array holds the window. Windows are emitted only when the
// whole neighbourhood lies inside the current frame.
//
// The line buffers are read one pixel ahead: after each accepted pixel the
// RAMs fetch the address of the next expected column, so the line data is
// already registered when that pixel arrives and the window can be updated
// on the same edge that accepts the pixel.
module sliding_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int K      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  sliding_window_gen_if.slave bus
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int NL   = K - 1;
  localparam int HALF = (K - 1) / 2;

  // Position and sync state
  logic [XW-1:0] x_q, x_eff, x_nxt, rd_addr;
  logic [YW-1:0] y_q, y_eff, y_nxt;
  logic          synced_q;
  logic          acc, x_wrap, emit, last_px;

  // Line buffer read data and the column entering the window
  logic [DATA_W-1:0] lb_rd  [NL];
  logic [DATA_W-1:0] col    [K];

  // Window registers and their next value
  logic [DATA_W-1:0]     win_q [K][K];
  logic [DATA_W-1:0]     win_n [K][K];
  logic [K*K*DATA_W-1:0] win_flat;

  // Output stage
  logic                  vld_p0;
  logic                  done_p0;
  logic [K*K*DATA_W-1:0] win_p0;
  logic [XW-1:0]         x_p0;
  logic [YW-1:0]         y_p0;

  // Accept decision, effective coordinates and next-position arithmetic
  always_comb begin
    acc     = bus.in_valid && (bus.in_sof || synced_q);
    x_eff   = bus.in_sof ? '0 : x_q;
    y_eff   = bus.in_sof ? '0 : y_q;
    x_wrap  = (x_eff == XW'(IMG_W - 1));
    x_nxt   = x_wrap ? '0 : x_eff + XW'(1);
    y_nxt   = y_eff;
    if (x_wrap) y_nxt = (y_eff == YW'(IMG_H - 1)) ? '0 : y_eff + YW'(1);
    emit    = acc && (x_eff >= XW'(K - 1)) && (y_eff >= YW'(K - 1));
    last_px = x_wrap && (y_eff == YW'(IMG_H - 1));
    rd_addr = acc ? x_nxt : x_q;
  end

  // K-1 chained line buffers: lb[0] stores the incoming pixel, lb[i] the
  // pixel lb[i-1] held for the same column.
  for (genvar i = 0; i < NL; i++) begin : g_lb
    logic [DATA_W-1:0] wr_data;
    if (i == 0) begin : g_first
      assign wr_data = bus.in_data;
    end else begin : g_chain
      assign wr_data = lb_rd[i-1];
    end
    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(XW)) u_lb (
      .clk     (clk),
      .en      (acc),
      .wr_addr (x_eff),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (lb_rd[i])
    );
  end

  // New column (top = oldest line) and the shifted window
  always_comb begin
    for (int r = 0; r < K; r++) begin
      col[r] = (r == K - 1) ? bus.in_data : lb_rd[K-2-r];
    end
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_n[r][c] = (c == K - 1) ? col[r] : win_q[r][c+1];
        win_flat[idx(r, c, K, DATA_W) +: DATA_W] = win_n[r][c];
      end
    end
  end

  // Frame sync and raster counters advance on every accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      synced_q <= 1'b0;
    end else if (acc) begin
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      synced_q <= 1'b1;
    end
  end

  // Window shift register: columns move left, the new column enters at c=K-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      end
    end else if (acc) begin
      win_q <= win_n;
    end
  end

  // Stage p0: registered window outputs, updated only for interior pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
      win_p0  <= '0;
      x_p0    <= '0;
      y_p0    <= '0;
    end else begin
      vld_p0  <= emit;
      done_p0 <= emit && last_px;
      if (emit) begin
        win_p0 <= win_flat;
        x_p0   <= x_eff - XW'(HALF);
        y_p0   <= y_eff - YW'(HALF);
      end
    end
  end

  assign bus.out_valid  = vld_p0;
  assign bus.frame_done = done_p0;
  assign bus.out_window = win_p0;
  assign bus.out_x      = x_p0;
  assign bus.out_y      = y_p0;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: an 8x6 image through a K=3 and a K=5
// instance driven in parallel, compared against a frame-buffer model.
module tb_sliding_window_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  sliding_window_gen_if #(.DATA_W(DW), .K(3), .IMG_W(W), .IMG_H(H)) if3 ();
  sliding_window_gen_if #(.DATA_W(DW), .K(5), .IMG_W(W), .IMG_H(H)) if5 ();

  sliding_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));
  sliding_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5.slave));

  typedef struct {
    logic [199:0] w;
    int           x;
    int           y;
    bit           fd;
    int           cyc;
  } rec_t;

  rec_t got3[$], got5[$], exp3[$], exp5[$];
  int   tests = 0;
  int   fails = 0;
  int   orphans = 0;
  logic prev3 = 1'b0;
  logic prev5 = 1'b0;

  // Reference model: a frame buffer indexed by (y,x) plus sync/position
  logic [DW-1:0] img [H][W];
  bit m_synced = 0;
  int m_x = 0;
  int m_y = 0;

  // Collect every emitted window; flag windows with no pixel the cycle before
  always @(negedge clk) begin : mon
    rec_t r;
    if (if3.out_valid) begin
      r.w = '0; r.w[71:0] = if3.out_window;
      r.x = int'(if3.out_x); r.y = int'(if3.out_y);
      r.fd = if3.frame_done; r.cyc = cyc;
      got3.push_back(r);
      if (!prev3) orphans++;
    end
    if (if5.out_valid) begin
      r.w = if5.out_window;
      r.x = int'(if5.out_x); r.y = int'(if5.out_y);
      r.fd = if5.frame_done; r.cyc = cyc;
      got5.push_back(r);
      if (!prev5) orphans++;
    end
    prev3 = if3.in_valid;
    prev5 = if5.in_valid;
  end

  task automatic set_in(input logic v, input logic s, input logic [DW-1:0] d);
    if3.in_valid = v; if3.in_sof = s; if3.in_data = d;
    if5.in_valid = v; if5.in_sof = s; if5.in_data = d;
  endtask

  // Model of one presented pixel: store it, emit windows whose whole
  // neighbourhood is inside the frame, advance the raster position.
  task automatic model_accept(input bit sof, input logic [DW-1:0] d);
    rec_t r;
    if (!(sof || m_synced)) return;
    if (sof) begin m_synced = 1; m_x = 0; m_y = 0; end
    img[m_y][m_x] = d;
    for (int kk = 3; kk <= 5; kk += 2) begin
      if (m_x >= kk - 1 && m_y >= kk - 1) begin
        r.w = '0;
        for (int rr = 0; rr < kk; rr++)
          for (int cc = 0; cc < kk; cc++)
            r.w[(rr*kk+cc)*DW +: DW] = img[m_y-kk+1+rr][m_x-kk+1+cc];
        r.x = m_x - (kk - 1) / 2;
        r.y = m_y - (kk - 1) / 2;
        r.fd = (m_x == W - 1 && m_y == H - 1);
        r.cyc = cyc + 1;
        if (kk == 3) exp3.push_back(r); else exp5.push_back(r);
      end
    end
    m_x++;
    if (m_x == W) begin
      m_x = 0; m_y++;
      if (m_y == H) m_y = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; set_in(1'b0, 1'b0, '0); end
  endtask

  task automatic send(input bit sof, input logic [DW-1:0] d, input int gap_pct);
    while ($urandom_range(99) < gap_pct) idle(1);
    @(posedge clk); #1;
    set_in(1'b1, sof, d);
    model_accept(sof, d);
  endtask

  task automatic frame(input int gap_pct, input bit rnd);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send(x == 0 && y == 0, rnd ? DW'($urandom) : DW'(y * 8 + x), gap_pct);
  endtask

  task automatic clear();
    idle(3);
    got3.delete(); got5.delete(); exp3.delete(); exp5.delete();
    orphans = 0;
  endtask

  task automatic model_reset();
    m_synced = 0; m_x = 0; m_y = 0;
  endtask

  function automatic int first_diff(input rec_t a[$], input rec_t b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++)
      if (a[i].w !== b[i].w || a[i].x != b[i].x || a[i].y != b[i].y ||
          a[i].fd != b[i].fd || a[i].cyc != b[i].cyc) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic int count_fd(input rec_t q[$]);
    int n = 0;
    foreach (q[i]) if (q[i].fd) n++;
    return n;
  endfunction

  task automatic test_reset();
    set_in(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #12;
    tests++; if (if3.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid3 got %b exp 0", if3.out_valid); end
    tests++; if (if3.out_window !== '0) begin fails++; $display("FAIL rst_window3 got %h exp 0", if3.out_window); end
    tests++; if (if3.out_x !== '0 || if3.out_y !== '0) begin fails++; $display("FAIL rst_xy3 got %0d,%0d exp 0,0", if3.out_x, if3.out_y); end
    tests++; if (if3.frame_done !== 1'b0 || if5.frame_done !== 1'b0) begin fails++; $display("FAIL rst_done got %b%b exp 00", if3.frame_done, if5.frame_done); end
    tests++; if (if5.out_valid !== 1'b0 || if5.out_window !== '0) begin fails++; $display("FAIL rst_out5 got %b/%h exp 0/0", if5.out_valid, if5.out_window); end
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_continuous();
    logic [199:0] ew;
    int d;
    clear();
    frame(0, 1'b0);
    idle(3);
    tests++; if (got3.size() != 24) begin fails++; $display("FAIL cont3_count got %0d exp 24", got3.size()); end
    d = first_diff(got3, exp3);
    tests++; if (d != -1) begin fails++; $display("FAIL cont3_seq first diff at %0d exp none (got %0d exp %0d)", d, got3.size(), exp3.size()); end
    ew = '0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ew[(r*3+c)*8 +: 8] = 8'(r * 8 + c);
    tests++;
    if (got3.size() == 0 || got3[0].w !== ew || got3[0].x != 1 || got3[0].y != 1) begin
      fails++; $display("FAIL cont3_first got %h exp %h at (1,1)", (got3.size() > 0) ? got3[0].w : '0, ew);
    end
    tests++;
    if (count_fd(got3) != 1 || got3.size() == 0 || !got3[$].fd || got3[$].x != 6 || got3[$].y != 4) begin
      fails++; $display("FAIL cont3_done got %0d pulses exp 1 at (6,4)", count_fd(got3));
    end
    tests++; if (got5.size() != 8) begin fails++; $display("FAIL cont5_count got %0d exp 8", got5.size()); end
    d = first_diff(got5, exp5);
    tests++; if (d != -1) begin fails++; $display("FAIL cont5_seq first diff at %0d exp none", d); end
    tests++;
    if (got5.size() == 0 || got5[0].w[39:0] !== 40'h04_03_02_01_00 || got5[0].x != 2 || got5[0].y != 2) begin
      fails++; $display("FAIL cont5_first got %h exp 0403020100 at (2,2)", (got5.size() > 0) ? got5[0].w[39:0] : '0);
    end
    tests++; if (count_fd(got5) != 1 || got5.size() == 0 || !got5[$].fd) begin fails++; $display("FAIL cont5_done got %0d pulses exp 1 on last", count_fd(got5)); end
  endtask

  task automatic test_gaps();
    int d;
    clear();
    frame(50, 1'b0);
    idle(3);
    tests++; if (got3.size() != 24) begin fails++; $display("FAIL gaps3_count got %0d exp 24", got3.size()); end
    d = first_diff(got3, exp3);
    tests++; if (d != -1) begin fails++; $display("FAIL gaps3_seq first diff at %0d exp none", d); end
    d = first_diff(got5, exp5);
    tests++; if (d != -1) begin fails++; $display("FAIL gaps5_seq first diff at %0d exp none", d); end
    tests++; if (orphans != 0) begin fails++; $display("FAIL gaps_orphan got %0d exp 0", orphans); end
  endtask

  task automatic test_back_to_back();
    int d;
    clear();
    frame(0, 1'b1);
    frame(30, 1'b1);
    idle(3);
    tests++; if (got3.size() != 48 || count_fd(got3) != 2) begin fails++; $display("FAIL b2b3_count got %0d/%0d exp 48/2", got3.size(), count_fd(got3)); end
    d = first_diff(got3, exp3);
    tests++; if (d != -1) begin fails++; $display("FAIL b2b3_seq first diff at %0d exp none", d); end
    d = first_diff(got5, exp5);
    tests++; if (d != -1 || got5.size() != 16) begin fails++; $display("FAIL b2b5_seq first diff at %0d size %0d exp none/16", d, got5.size()); end
  endtask

  task automatic test_presof();
    int d;
    @(posedge clk); #3; rst_n = 1'b0; set_in(1'b0, 1'b0, '0);
    #10 rst_n = 1'b1;
    model_reset();
    clear();
    for (int i = 0; i < 10; i++) send(1'b0, DW'($urandom), 20);
    idle(3);
    tests++; if (got3.size() != 0 || got5.size() != 0) begin fails++; $display("FAIL presof_drop got %0d/%0d exp 0/0", got3.size(), got5.size()); end
    frame(0, 1'b0);
    idle(3);
    d = first_diff(got3, exp3);
    tests++; if (d != -1 || got3.size() != 24) begin fails++; $display("FAIL presof3_seq diff %0d size %0d exp none/24", d, got3.size()); end
    d = first_diff(got5, exp5);
    tests++; if (d != -1 || got5.size() != 8) begin fails++; $display("FAIL presof5_seq diff %0d size %0d exp none/8", d, got5.size()); end
  endtask

  task automatic test_abort();
    int d;
    clear();
    for (int p = 0; p < 30; p++) send(p == 0, DW'(p), 0);
    frame(0, 1'b0);
    idle(3);
    tests++; if (got3.size() != 34) begin fails++; $display("FAIL abort3_count got %0d exp 34", got3.size()); end
    tests++; if (count_fd(got3) != 1 || !got3[$].fd) begin fails++; $display("FAIL abort3_done got %0d exp 1 on last", count_fd(got3)); end
    d = first_diff(got3, exp3);
    tests++; if (d != -1) begin fails++; $display("FAIL abort3_seq first diff at %0d exp none", d); end
    d = first_diff(got5, exp5);
    tests++; if (d != -1 || got5.size() != 8) begin fails++; $display("FAIL abort5_seq diff %0d size %0d exp none/8", d, got5.size()); end
  endtask

  task automatic test_async_reset();
    int d;
    clear();
    for (int p = 0; p < 20; p++) send(p == 0, DW'(p), 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, '0);
    #1;
    tests++; if (if3.out_valid !== 1'b0 || if3.out_x !== '0 || if3.out_y !== '0) begin fails++; $display("FAIL arst_ctl3 got %b %0d %0d exp 0 0 0", if3.out_valid, if3.out_x, if3.out_y); end
    tests++; if (if3.out_window !== '0 || if3.frame_done !== 1'b0) begin fails++; $display("FAIL arst_win3 got %h exp 0", if3.out_window); end
    #7 rst_n = 1'b1;
    model_reset();
    clear();
    for (int i = 0; i < 6; i++) send(1'b0, DW'($urandom), 0);
    frame(20, 1'b0);
    idle(3);
    d = first_diff(got3, exp3);
    tests++; if (d != -1 || got3.size() != 24) begin fails++; $display("FAIL arst3_seq diff %0d size %0d exp none/24", d, got3.size()); end
    d = first_diff(got5, exp5);
    tests++; if (d != -1 || got5.size() != 8) begin fails++; $display("FAIL arst5_seq diff %0d size %0d exp none/8", d, got5.size()); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_presof();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
